gray_wptr_gen_32: RTL and testbench

- Write-side pointer generator for the pcs25g clock-crossing FIFOs. It is the encode direction of the binary/Gray pair.
- Keeps a binary write pointer and advances it on accepted pushes. The pointer is published as a registered 5-bit Gray code, so exactly one bit toggles per advance and it is safe to sample in the read domain.
- Synchronises the read side's Gray pointer into clk, decodes it to binary, and derives full, level and overflow.
- Sits between the lane write logic and the FIFO RAM write port.

---
 rtl/gray_wptr_gen_32.sv | 103 ++++++++++
 tb/tb_gray_wptr_gen_32.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_wptr_gen_32.sv
// gray_wptr_gen_32 -- write-side pointer generator for the pcs25g clock-crossing FIFOs.
// Keeps a binary write pointer and publishes it as a registered Gray code.
// Brings the read side's Gray pointer into clk through a flop chain.
// Derives full, level and overflow from the synchronised read pointer.
// full and level can lag the true occupancy, but they never under-report it.

module gray_wptr_gen_32 #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic [ADDR_W:0]   rptr_gray_async,
    output logic [ADDR_W-1:0] waddr,
    output logic              wen,
    output logic [ADDR_W:0]   wptr_gray,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              ovf
);

    localparam int PTR_W = ADDR_W + 1;

    // Binary to Gray: adjacent binary values differ in exactly one Gray bit.
    function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: prefix XOR running down from the MSB.
    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_W-1:0] wbin_r;
    logic [PTR_W-1:0] wptr_gray_r;
    logic             full_r;
    logic [PTR_W-1:0] level_r;
    logic             ovf_r;
    logic [PTR_W-1:0] sync_r [SYNC_STAGES];

    logic             push_ok_s;
    logic [PTR_W-1:0] wbin_next_s;
    logic [PTR_W-1:0] gray_next_s;
    logic [PTR_W-1:0] rptr_sync_s;
    logic [PTR_W-1:0] rbin_s;
    logic [PTR_W-1:0] full_match_s;

    // Accept rule, next pointer values and the Gray code of a pointer exactly half a ring ahead of the reader.
    always_comb begin
        push_ok_s    = inc & ~full_r;
        wbin_next_s  = wbin_r + {{(PTR_W-1){1'b0}}, push_ok_s};
        gray_next_s  = bin2gray(wbin_next_s);
        rptr_sync_s  = sync_r[SYNC_STAGES-1];
        rbin_s       = gray2bin(rptr_sync_s);
        full_match_s = {~rptr_sync_s[PTR_W-1], ~rptr_sync_s[PTR_W-2], rptr_sync_s[PTR_W-3:0]};
    end

    // Read pointer synchroniser chain; stage 0 is the only flop fed from the other clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= {PTR_W{1'b0}};
            end
        end else begin
            sync_r[0] <= rptr_gray_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // Write pointer, Gray output and status flags all update on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbin_r      <= {PTR_W{1'b0}};
            wptr_gray_r <= {PTR_W{1'b0}};
            full_r      <= 1'b0;
            level_r     <= {PTR_W{1'b0}};
            ovf_r       <= 1'b0;
        end else begin
            wbin_r      <= wbin_next_s;
            wptr_gray_r <= gray_next_s;
            full_r      <= (gray_next_s == full_match_s);
            level_r     <= wbin_next_s - rbin_s;
            ovf_r       <= inc & full_r;
        end
    end

    // wptr_gray is driven straight from its flop so the read domain never samples a glitch.
    assign wptr_gray = wptr_gray_r;
    assign waddr     = wbin_r[ADDR_W-1:0];
    assign wen       = push_ok_s;
    assign full      = full_r;
    assign level     = level_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_gray_wptr_gen_32.sv
// Self-checking bench for gray_wptr_gen_32: an occupancy-level model plus directed literal checks.
module tb_gray_wptr_gen_32;

    localparam int SYNC = 2;

    logic       clk;
    logic       reset;
    logic       inc;
    logic [4:0] rptr_gray_async;
    logic [3:0] waddr;
    logic       wen;
    logic [4:0] wptr_gray;
    logic       full;
    logic [4:0] level;
    logic       ovf;

    int tests;
    int fails;

    gray_wptr_gen_32 #(.ADDR_W(4), .SYNC_STAGES(SYNC)) dut (
        .clk             (clk),
        .reset           (reset),
        .inc             (inc),
        .rptr_gray_async (rptr_gray_async),
        .waddr           (waddr),
        .wen             (wen),
        .wptr_gray       (wptr_gray),
        .full            (full),
        .level           (level),
        .ovf             (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: pointers as counters, occupancy as a difference ----------------
    function automatic logic [4:0] m_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // Decode by search: the binary value whose Gray code matches.
    function automatic logic [4:0] m_decode(input logic [4:0] g);
        logic [4:0] r;
        r = 5'd0;
        for (int v = 0; v < 32; v++) begin
            if (m_gray(5'(v)) == g) r = 5'(v);
        end
        return r;
    endfunction

    function automatic logic [4:0] m_next(input logic [4:0] w, input logic i, input logic f);
        return (i && !f) ? 5'(w + 5'd1) : w;
    endfunction

    logic [4:0] m_wbin;
    logic       m_full;
    logic [4:0] m_level;
    logic       m_ovf;
    logic [4:0] m_sync [SYNC];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_wbin  <= 5'd0;
            m_full  <= 1'b0;
            m_level <= 5'd0;
            m_ovf   <= 1'b0;
            for (int i = 0; i < SYNC; i++) m_sync[i] <= 5'd0;
        end else begin
            m_wbin  <= m_next(m_wbin, inc, m_full);
            m_full  <= (5'(m_next(m_wbin, inc, m_full) - m_decode(m_sync[SYNC-1])) == 5'd16);
            m_level <= 5'(m_next(m_wbin, inc, m_full) - m_decode(m_sync[SYNC-1]));
            m_ovf   <= inc & m_full;
            m_sync[0] <= rptr_gray_async;
            for (int i = 1; i < SYNC; i++) m_sync[i] <= m_sync[i-1];
        end
    end

    // ---------------- per-cycle compare, away from the active edge ----------------
    logic [4:0] prev_gray;
    logic [4:0] prev_wbin;

    always @(negedge clk) begin
        if (reset) begin
            prev_gray <= 5'd0;
            prev_wbin <= 5'd0;
        end else begin
            check("cyc_wptr_gray", {27'd0, wptr_gray}, {27'd0, m_gray(m_wbin)});
            check("cyc_waddr", {28'd0, waddr}, {28'd0, m_wbin[3:0]});
            check("cyc_wen", {31'd0, wen}, {31'd0, inc & ~m_full});
            check("cyc_full", {31'd0, full}, {31'd0, m_full});
            check("cyc_level", {27'd0, level}, {27'd0, m_level});
            check("cyc_ovf", {31'd0, ovf}, {31'd0, m_ovf});
            check("cyc_one_bit_step", $countones(wptr_gray ^ prev_gray), (m_wbin != prev_wbin) ? 32'd1 : 32'd0);
            prev_gray <= wptr_gray;
            prev_wbin <= m_wbin;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        inc             = 1'b0;
        rptr_gray_async = 5'd0;
        reset           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [4:0] exp_seq [16];

    initial begin
        int n;
        bit found;
        tests = 0;
        fails = 0;
        clk   = 1'b0;
        exp_seq = '{5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111, 5'b00101, 5'b00100, 5'b01100,
                    5'b01101, 5'b01111, 5'b01110, 5'b01010, 5'b01011, 5'b01001, 5'b01000, 5'b11000};

        // Reset then idle.
        do_reset();
        check("rst_wptr_gray", {27'd0, wptr_gray}, 32'd0);
        check("rst_level", {27'd0, level}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        repeat (10) tick();
        check("idle_wptr_gray", {27'd0, wptr_gray}, 32'd0);
        check("idle_level", {27'd0, level}, 32'd0);

        // Count sequence: 16 pushes against an empty reader.
        for (int i = 0; i < 16; i++) begin
            inc = 1'b1;
            #1;
            check("count_waddr", {28'd0, waddr}, i);
            check("count_wen", {31'd0, wen}, 32'd1);
            tick();
            check("count_gray", {27'd0, wptr_gray}, {27'd0, exp_seq[i]});
        end
        check("count_full", {31'd0, full}, 32'd1);
        check("count_level", {27'd0, level}, 32'd16);

        // Overflow: three rejected pushes.
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ovf_wen", {31'd0, wen}, 32'd0);
            tick();
            check("ovf_pulse", {31'd0, ovf}, 32'd1);
            check("ovf_gray_hold", {27'd0, wptr_gray}, 32'b11000);
        end
        inc = 1'b0;
        tick();
        check("ovf_clear", {31'd0, ovf}, 32'd0);

        // Drain release: reader moves to 1, full clears after the sync latency plus one edge.
        rptr_gray_async = 5'b00001;
        n = 0;
        found = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (!found) begin
                tick();
                if (!full) begin
                    n = k;
                    found = 1'b1;
                end
            end
        end
        check("drain_latency", n, SYNC + 1);
        check("drain_level", {27'd0, level}, 32'd15);
        inc = 1'b1;
        tick();
        inc = 1'b0;
        check("drain_next_gray", {27'd0, wptr_gray}, 32'b11001);
        check("drain_level_after", {27'd0, level}, 32'd16);

        // Wrap-around with a reader that tracks the writer.
        do_reset();
        for (int i = 1; i <= 40; i++) begin
            inc = 1'b1;
            tick();
            rptr_gray_async = m_gray(5'(i));
            if (i == 31) check("wrap_gray_31", {27'd0, wptr_gray}, 32'b10000);
            if (i == 32) check("wrap_gray_32", {27'd0, wptr_gray}, 32'b00000);
            check("wrap_level_bound", {31'd0, (level <= 5'd16)}, 32'd1);
        end
        inc = 1'b0;
        repeat (4) tick();
        check("wrap_settled_level", {27'd0, level}, 32'd0);

        // Mid-run asynchronous reset at wbin=9.
        do_reset();
        inc = 1'b1;
        repeat (9) tick();
        inc = 1'b0;
        check("mid_gray_9", {27'd0, wptr_gray}, 32'b01101);
        check("mid_level_9", {27'd0, level}, 32'd9);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_gray", {27'd0, wptr_gray}, 32'd0);
        check("mid_rst_level", {27'd0, level}, 32'd0);
        check("mid_rst_full", {31'd0, full}, 32'd0);
        tick();
        reset = 1'b0;
        inc = 1'b1;
        tick();
        inc = 1'b0;
        check("mid_restart_gray", {27'd0, wptr_gray}, 32'b00001);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
